// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM (1-cycle registered read) between
// an instruction-fetch port and a data load/store port. Round-robin on ties.
module mem_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic [CW-1:0] i_count,
    output logic [CW-1:0] d_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nxt;
    logic   take, grant_d;
    logic   owner_d, last_d, we_q, write_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // last_d == 0 means I owned the previous grant, so D wins a tie.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take      = 1'b1;
                    grant_d   = d_req && (!i_req || !last_d);
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            we_q      <= 1'b0;
            ram_read  <= 1'b0;
            write_q   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
            i_count   <= '0;
            d_count   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        owner_d   <= grant_d;
                        last_d    <= grant_d;
                        we_q      <= grant_d && d_we;
                        ram_read  <= !(grant_d && d_we);
                        write_q   <= grant_d && d_we;
                        ram_addr  <= grant_d ? d_addr : i_addr;
                        ram_wdata <= (grant_d && d_we) ? d_wdata : '0;
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    ram_read  <= 1'b0;
                    write_q   <= 1'b0;
                    ram_wdata <= '0;
                    d_ack     <= owner_d;
                    i_ack     <= !owner_d;
                    if (owner_d) begin
                        if (d_count != '1) d_count <= d_count + 1'b1;
                    end else begin
                        if (i_count != '1) i_count <= i_count + 1'b1;
                    end
                end
                DONE:    busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end

    // A write whose sampling edge sees reset must not reach the RAM.
    assign ram_write = write_q && !reset;

    assign i_rdata = i_ack ? ram_rdata : '0;
    assign d_rdata = (d_ack && !we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, transaction-level reference model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          ram_read, ram_write, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [CW-1:0] i_count, d_count;

    int n_checks = 0;
    int n_fail = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .i_count(i_count), .d_count(d_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // RAM: registered read, write on posedge
    logic [DW-1:0] ram_mem [512];
    logic [DW-1:0] m_mem   [512];
    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'(i) ^ 32'hA5A5_0000;
            m_mem[i]   = 32'(i) ^ 32'hA5A5_0000;
        end
        ram_mem[9'h0EA] = 32'h19;
        m_mem[9'h0EA]   = 32'h19;
    end
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model: each grant occupies the next two edges (strobes, then ack).
    bit            started = 0;
    int            rem = 0;
    bit            m_last_d, m_own_d, m_we;
    logic [AW-1:0] m_addr;
    logic          e_read, e_write, e_iack, e_dack, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_ird, e_drd;
    logic [CW-1:0] e_icnt, e_dcnt;

    always @(posedge clk) begin
        if (reset) begin
            started = 1; rem = 0; m_last_d = 0;
            e_read = 0; e_write = 0; e_addr = '0; e_wdata = '0;
            e_iack = 0; e_dack = 0; e_ird = '0; e_drd = '0;
            e_busy = 0; e_icnt = '0; e_dcnt = '0;
        end else begin
            e_iack = 0; e_dack = 0; e_ird = '0; e_drd = '0;
            if (rem == 2) begin
                e_read = 0; e_write = 0; e_wdata = '0;
                if (m_own_d) begin
                    e_dack = 1;
                    e_drd  = m_we ? '0 : m_mem[m_addr];
                    if (e_dcnt != CMAX) e_dcnt = e_dcnt + 1'b1;
                end else begin
                    e_iack = 1;
                    e_ird  = m_mem[m_addr];
                    if (e_icnt != CMAX) e_icnt = e_icnt + 1'b1;
                end
                if (m_we) m_mem[m_addr] = d_wdata;
                rem = 1;
            end else if (rem == 1) begin
                e_busy = 0;
                rem = 0;
            end else if (i_req || d_req) begin
                m_own_d  = d_req && !(i_req && m_last_d);
                m_last_d = m_own_d;
                m_we     = m_own_d && d_we;
                m_addr   = m_own_d ? d_addr : i_addr;
                e_read   = !m_we;
                e_write  = m_we;
                e_addr   = m_addr;
                e_wdata  = m_we ? d_wdata : '0;
                e_busy   = 1;
                rem = 2;
            end
        end
    end

    int wr_pulses = 0, d_acks = 0, i_acks = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("ram_read",  32'(ram_read),  32'(e_read));
            chk("ram_write", 32'(ram_write), 32'(e_write && !reset));
            chk("ram_addr",  32'(ram_addr),  32'(e_addr));
            chk("ram_wdata", ram_wdata, e_wdata);
            chk("i_ack",     32'(i_ack),     32'(e_iack));
            chk("d_ack",     32'(d_ack),     32'(e_dack));
            chk("i_rdata",   i_rdata, e_ird);
            chk("d_rdata",   d_rdata, e_drd);
            chk("busy",      32'(busy),      32'(e_busy));
            chk("i_count",   32'(i_count),   32'(e_icnt));
            chk("d_count",   32'(d_count),   32'(e_dcnt));
            if (ram_write) wr_pulses++;
            if (d_ack) d_acks++;
            if (i_ack) i_acks++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue one op, wait for its ack (bounded), then let the FSM return to IDLE.
    task automatic do_op(input bit is_d, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
        lat = -1;
        rd  = '0;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = a;
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (is_d ? d_ack : i_ack) begin
                lat = t;
                rd  = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        d_req = 0;
        i_req = 0;
        if (lat < 0) chk("op_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int lat, w0, a0, dc, ic, nacks;
        logic [DW-1:0] rd;
        int seq [$];

        pulse_reset();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dcnt", 32'(d_count), 0);
        chk("reset_addr", 32'(ram_addr), 0);

        // 1: store 0x25 to 0x034
        w0 = wr_pulses;
        do_op(1, 1, 9'h034, 32'h25, lat, rd);
        chk("t1_latency", 32'(lat), 2);
        chk("t1_wr_pulses", 32'(wr_pulses - w0), 1);
        chk("t1_dcount", 32'(d_count), 1);

        // 2: load back
        a0 = i_acks;
        do_op(1, 0, 9'h034, '0, lat, rd);
        chk("t2_latency", 32'(lat), 2);
        chk("t2_rdata", rd, 32'h25);
        chk("t2_no_iack", 32'(i_acks - a0), 0);

        // 3: simultaneous requests from reset, D wins first
        pulse_reset();
        i_req = 1; i_addr = 9'h000;
        d_req = 1; d_we = 0; d_addr = 9'h054;
        dc = -1; ic = -1;
        for (int t = 1; t <= 20 && (dc < 0 || ic < 0); t++) begin
            tick();
            if (d_ack) begin dc = t; d_req = 0; end
            if (i_ack) begin ic = t; i_req = 0; end
        end
        d_req = 0; i_req = 0;
        chk("t3_d_cycle", 32'(dc), 2);
        chk("t3_i_cycle", 32'(ic), 5);
        chk("t3_icount", 32'(i_count), 1);
        chk("t3_dcount", 32'(d_count), 1);
        tick();

        // 4: both held for 12 cycles; I owned last, so D first, then alternate
        i_req = 1; i_addr = 9'h010;
        d_req = 1; d_we = 0; d_addr = 9'h034;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (d_ack) seq.push_back(1);
            if (i_ack) seq.push_back(0);
        end
        i_req = 0; d_req = 0;
        nacks = seq.size();
        chk("t4_nacks", 32'(nacks), 4);
        if (nacks > 0) chk("t4_first_d", 32'(seq[0]), 1);
        for (int k = 1; k < nacks; k++) chk("t4_alternate", 32'(seq[k] != seq[k-1]), 1);
        tick(); tick(); tick();
        chk("t4_icount", 32'(i_count), 3);
        chk("t4_dcount", 32'(d_count), 3);

        // 5: reset during ACCESS of a store suppresses the write
        pulse_reset();
        a0 = d_acks;
        d_req = 1; d_we = 1; d_addr = 9'h0EA; d_wdata = 32'hDEAD;
        tick();
        chk("t5_in_access", 32'(ram_write), 1);
        reset = 1; d_req = 0;
        tick();
        reset = 0;
        tick(); tick(); tick();
        chk("t5_ram_kept", ram_mem[9'h0EA], 32'h19);
        chk("t5_no_ack", 32'(d_acks - a0), 0);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_dcount", 32'(d_count), 0);
        chk("t5_icount", 32'(i_count), 0);

        // 6: d_count saturates at 0xF
        for (int k = 0; k < 15; k++) do_op(1, 1, AW'(k + 9'h100), 32'(k), lat, rd);
        chk("t6_dcount_15", 32'(d_count), 32'hF);
        do_op(1, 1, 9'h1F0, 32'h77, lat, rd);
        chk("t6_last_latency", 32'(lat), 2);
        chk("t6_dcount_sat", 32'(d_count), 32'hF);
        chk("t6_ram_written", ram_mem[9'h1F0], 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
